// File: rtl/ab_word_decoder.sv
// Serial A/B duty-word decoder: start, 2*DATA_W payload bits MSB first, even parity, stop.
// Define AB_DECODE_MAJORITY_EN to take each bit as a 2-of-3 vote around mid-bit.
module ab_word_decoder #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_W     = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_en,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] A_val,
    output logic [DATA_W-1:0] B_val,
    output logic              done,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int PW = 2 * DATA_W;
    localparam int BW = (PW > 2) ? $clog2(PW) : 1;
    localparam logic [TW-1:0] MID      = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST     = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(PW - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t          state, state_n;
    logic [1:0]      sync_q;
    logic            line;
    logic [TW-1:0]   tick_cnt, tick_n, pos;
    logic [BW-1:0]   bit_cnt, bit_n;
    logic [PW-1:0]   shift_q, shift_n;
    logic            par_bad, par_n;
    logic [DATA_W-1:0] a_n, b_n;
    logic            done_n, perr_n, ferr_n;
    logic            sample_fire, sample_bit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '1;
        else        sync_q <= {sync_q[0], rx_bit};
    end

    assign line = sync_q[1];

    // Bit phase of the current tick; the start-detection tick is phase 0.
    assign pos = (state == IDLE) ? '0 : (tick_cnt == LAST) ? '0 : tick_cnt + 1'b1;

`ifdef AB_DECODE_MAJORITY_EN
    localparam logic [TW-1:0] MID_M1 = TW'(OVERSAMPLE / 2 - 2);
    localparam logic [TW-1:0] MID_P1 = TW'(OVERSAMPLE / 2);
    logic [1:0] vote_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vote_q <= '0;
        end else if (sample_en) begin
            if (pos == MID_M1) vote_q[0] <= line;
            if (pos == MID)    vote_q[1] <= line;
        end
    end

    assign sample_fire = sample_en && (pos == MID_P1);
    assign sample_bit  = (vote_q[0] & vote_q[1]) | (vote_q[0] & line) | (vote_q[1] & line);
`else
    assign sample_fire = sample_en && (pos == MID);
    assign sample_bit  = line;
`endif

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_q;
        par_n   = par_bad;
        a_n     = A_val;
        b_n     = B_val;
        done_n  = 1'b0;
        perr_n  = 1'b0;
        ferr_n  = 1'b0;
        if (sample_en) tick_n = pos;
        case (state)
            IDLE: begin
                if (sample_en && !line) begin
                    state_n = START;
                    bit_n   = '0;
                end
            end
            START: begin
                if (sample_fire) state_n = sample_bit ? IDLE : DATA;
            end
            DATA: begin
                if (sample_fire) begin
                    shift_n = {shift_q[PW-2:0], sample_bit};
                    bit_n   = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) state_n = PARITY;
                end
            end
            PARITY: begin
                if (sample_fire) begin
                    par_n   = ^{shift_q, sample_bit};
                    state_n = STOP;
                end
            end
            STOP: begin
                if (sample_fire) begin
                    if (sample_bit) begin
                        state_n = IDLE;
                        if (par_bad) begin
                            perr_n = 1'b1;
                        end else begin
                            a_n    = shift_q[PW-1:DATA_W];
                            b_n    = shift_q[DATA_W-1:0];
                            done_n = 1'b1;
                        end
                    end else begin
                        // A low stop bit means the line may be held in break; wait for it to rise.
                        state_n = BREAK;
                        ferr_n  = 1'b1;
                        perr_n  = par_bad;
                    end
                end
            end
            BREAK: begin
                if (sample_en && line) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            par_bad    <= 1'b0;
            A_val      <= '0;
            B_val      <= '0;
            done       <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            tick_cnt   <= tick_n;
            bit_cnt    <= bit_n;
            shift_q    <= shift_n;
            par_bad    <= par_n;
            A_val      <= a_n;
            B_val      <= b_n;
            done       <= done_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ab_word_decoder.sv
// Randomized self-checking bench for ab_word_decoder against a tick-stream reference model.
// Honours AB_DECODE_MAJORITY_EN in the model the same way the design does.
module tb_ab_word_decoder;

    localparam int OS  = 8;
    localparam int DW  = 7;
    localparam int MID = OS / 2 - 1;
`ifdef AB_DECODE_MAJORITY_EN
    localparam int DEC = MID + 1;
`else
    localparam int DEC = MID;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sample_en = 1'b0;
    logic          rx_bit = 1'b1;
    logic [DW-1:0] A_val, B_val;
    logic          done, parity_err, frame_err, busy;

    int checks = 0;
    int failures = 0;
    int tick_no = 0;
    int busy_ticks = 0;
    int first_evt = -1;
    int last_evt = -1;
    int n_done = 0, n_perr = 0, n_ferr = 0, n_overlap = 0, n_long = 0, n_stray = 0;
    logic prev_done = 1'b0, prev_perr = 1'b0, prev_ferr = 1'b0;
    logic [DW-1:0] prev_a = '0, prev_b = '0;
    logic [DW-1:0] model_a = '0, model_b = '0;
    logic ticks_q[$];

    ab_word_decoder #(.OVERSAMPLE(OS), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .rx_bit(rx_bit),
        .A_val(A_val), .B_val(B_val), .done(done), .parity_err(parity_err),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pulse accounting: counts, overlaps, over-long pulses and output changes without done.
    always @(negedge clk) begin
        if (reset) begin
            if (done)       n_done++;
            if (parity_err) n_perr++;
            if (frame_err)  n_ferr++;
            if (done && (parity_err || frame_err)) n_overlap++;
            if ((done && prev_done) || (parity_err && prev_perr) || (frame_err && prev_ferr)) n_long++;
            if (!done && (A_val !== prev_a || B_val !== prev_b)) n_stray++;
        end
        prev_done = done; prev_perr = parity_err; prev_ferr = frame_err;
        prev_a = A_val;   prev_b = B_val;
    end

    // One sample tick every 4 clocks; rx_bit settles through the synchronizer before the tick.
    task automatic drive_tick(input logic b);
        rx_bit = b;
        sample_en = 1'b0;
        repeat (3) @(negedge clk);
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        if (busy) busy_ticks++;
        if (done || parity_err || frame_err) begin
            if (first_evt < 0) first_evt = tick_no;
            last_evt = tick_no;
        end
        tick_no++;
    endtask

    task automatic send_queue();
        foreach (ticks_q[i]) drive_tick(ticks_q[i]);
    endtask

    task automatic build_frame(input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic pflip, input logic stop);
        logic bits [17];
        logic [2*DW-1:0] pay;
        pay = {a, b};
        bits[0] = 1'b0;
        for (int k = 0; k < 2 * DW; k++) bits[k+1] = pay[2*DW-1-k];
        bits[15] = (^pay) ^ pflip;
        bits[16] = stop;
        ticks_q.delete();
        for (int i = 0; i < 17; i++)
            for (int t = 0; t < OS; t++) ticks_q.push_back(bits[i]);
    endtask

    function automatic logic rx_sample(input int base);
`ifdef AB_DECODE_MAJORITY_EN
        int ones;
        ones = int'(ticks_q[base+MID-1]) + int'(ticks_q[base+MID]) + int'(ticks_q[base+MID+1]);
        return ones >= 2;
`else
        return ticks_q[base+MID];
`endif
    endfunction

    // Reference decode of a frame whose start bit begins at ticks_q[off].
    task automatic model_frame(input int off, output logic e_done, output logic e_perr,
                               output logic e_ferr, output logic [DW-1:0] ea, output logic [DW-1:0] eb);
        logic [2*DW-1:0] pay;
        logic p, s;
        for (int k = 0; k < 2 * DW; k++) pay[2*DW-1-k] = rx_sample(off + (k + 1) * OS);
        p = rx_sample(off + 15 * OS);
        s = rx_sample(off + 16 * OS);
        e_ferr = !s;
        e_perr = (^pay) ^ p;
        e_done = s && !e_perr;
        ea = pay[2*DW-1:DW];
        eb = pay[DW-1:0];
    endtask

    task automatic run_frame(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic pflip, input logic stop, input int glitch, input int extra_low);
        logic ed, ep, ef;
        logic [DW-1:0] ea, eb;
        int d0, p0, f0, o0, l0, s0, start, exp_busy;
        build_frame(a, b, pflip, stop);
        if (glitch >= 0) ticks_q[glitch] = ~ticks_q[glitch];
        model_frame(0, ed, ep, ef, ea, eb);
        if (ed) begin model_a = ea; model_b = eb; end
        for (int i = 0; i < extra_low; i++) ticks_q.push_back(1'b0);
        for (int i = 0; i < 2 * OS; i++) ticks_q.push_back(1'b1);
        d0 = n_done; p0 = n_perr; f0 = n_ferr; o0 = n_overlap; l0 = n_long; s0 = n_stray;
        busy_ticks = 0; first_evt = -1; start = tick_no;
        exp_busy = ef ? 17 * OS + extra_low : 16 * OS + DEC;
        send_queue();
        checks++; if (n_done - d0 !== int'(ed)) begin failures++; $display("FAIL %s done_count got=%0d exp=%0d", name, n_done - d0, ed); end
        checks++; if (n_perr - p0 !== int'(ep)) begin failures++; $display("FAIL %s perr_count got=%0d exp=%0d", name, n_perr - p0, ep); end
        checks++; if (n_ferr - f0 !== int'(ef)) begin failures++; $display("FAIL %s ferr_count got=%0d exp=%0d", name, n_ferr - f0, ef); end
        checks++; if (A_val !== model_a) begin failures++; $display("FAIL %s A_val got=%h exp=%h", name, A_val, model_a); end
        checks++; if (B_val !== model_b) begin failures++; $display("FAIL %s B_val got=%h exp=%h", name, B_val, model_b); end
        checks++; if (first_evt !== start + 16 * OS + DEC) begin failures++; $display("FAIL %s event_tick got=%0d exp=%0d", name, first_evt, start + 16 * OS + DEC); end
        checks++; if (busy_ticks !== exp_busy) begin failures++; $display("FAIL %s busy_ticks got=%0d exp=%0d", name, busy_ticks, exp_busy); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_end got=%b exp=0", name, busy); end
        checks++; if ((n_overlap - o0) + (n_long - l0) + (n_stray - s0) !== 0) begin
            failures++; $display("FAIL %s pulse_rules got=%0d/%0d/%0d exp=0/0/0", name, n_overlap - o0, n_long - l0, n_stray - s0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_bit = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (A_val !== '0 || B_val !== '0) begin failures++; $display("FAIL reset_ab got=%h/%h exp=00/00", A_val, B_val); end
        checks++; if ({done, parity_err, frame_err, busy} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {done, parity_err, frame_err, busy}); end
        reset = 1'b1;
        repeat (2 * OS) drive_tick(1'b1);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_parity_error();
        run_frame("parity_err", 7'h55, 7'h2A, 1'b1, 1'b1, -1, 0);
    endtask

    task automatic test_valid_frame();
        run_frame("valid_55_2a", 7'h55, 7'h2A, 1'b0, 1'b1, -1, 0);
    endtask

    task automatic test_frame_error();
        run_frame("frame_err_break", 7'h55, 7'h2A, 1'b0, 1'b0, -1, 3 * OS);
    endtask

    task automatic test_false_start();
        int d0, p0, f0;
        d0 = n_done; p0 = n_perr; f0 = n_ferr;
        busy_ticks = 0; first_evt = -1;
        drive_tick(1'b0); drive_tick(1'b0);
        repeat (2 * OS) drive_tick(1'b1);
        checks++; if (busy_ticks !== DEC) begin failures++; $display("FAIL false_start_busy got=%0d exp=%0d", busy_ticks, DEC); end
        checks++; if ((n_done - d0) + (n_perr - p0) + (n_ferr - f0) !== 0 || first_evt !== -1) begin
            failures++; $display("FAIL false_start_pulses got=%0d exp=0", (n_done - d0) + (n_perr - p0) + (n_ferr - f0));
        end
        run_frame("after_false_start", 7'($urandom), 7'($urandom), 1'b0, 1'b1, -1, 0);
    endtask

    task automatic test_reset_mid_frame();
        build_frame(7'h33, 7'h4C, 1'b0, 1'b1);
        for (int i = 0; i <= 5 * OS + MID; i++) drive_tick(ticks_q[i]);
        reset = 1'b0;
        #1;
        checks++; if (A_val !== '0 || B_val !== '0) begin failures++; $display("FAIL midreset_ab got=%h/%h exp=00/00", A_val, B_val); end
        checks++; if ({done, parity_err, frame_err, busy} !== 4'b0) begin failures++; $display("FAIL midreset_flags got=%b exp=0000", {done, parity_err, frame_err, busy}); end
        rx_bit = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_a = '0; model_b = '0;
        repeat (2 * OS) drive_tick(1'b1);
        run_frame("after_reset_7f_01", 7'h7F, 7'h01, 1'b0, 1'b1, -1, 0);
    endtask

    task automatic test_glitch();
        run_frame("mid_glitch_a3", 7'h55, 7'h2A, 1'b0, 1'b1, 4 * OS + MID, 0);
    endtask

    task automatic test_back_to_back();
        logic q2 [$];
        logic ed1, ep1, ef1, ed2, ep2, ef2;
        logic [DW-1:0] a1, b1, ea, eb;
        int d0, len1, start;
        build_frame(7'($urandom), 7'($urandom), 1'b0, 1'b1);
        q2 = ticks_q;
        a1 = 7'($urandom); b1 = 7'($urandom);
        build_frame(a1, b1, 1'b0, 1'b1);
        model_frame(0, ed1, ep1, ef1, ea, eb);
        repeat (OS - DEC - 1) void'(ticks_q.pop_back());
        len1 = ticks_q.size();
        foreach (q2[i]) ticks_q.push_back(q2[i]);
        model_frame(len1, ed2, ep2, ef2, ea, eb);
        for (int i = 0; i < 2 * OS; i++) ticks_q.push_back(1'b1);
        model_a = ea; model_b = eb;
        d0 = n_done; first_evt = -1; last_evt = -1; start = tick_no;
        send_queue();
        checks++; if (n_done - d0 !== int'(ed1) + int'(ed2)) begin failures++; $display("FAIL b2b_done_count got=%0d exp=%0d", n_done - d0, int'(ed1) + int'(ed2)); end
        checks++; if (first_evt !== start + 16 * OS + DEC) begin failures++; $display("FAIL b2b_first_tick got=%0d exp=%0d", first_evt, start + 16 * OS + DEC); end
        checks++; if (last_evt !== start + len1 + 16 * OS + DEC) begin failures++; $display("FAIL b2b_second_tick got=%0d exp=%0d", last_evt, start + len1 + 16 * OS + DEC); end
        checks++; if (A_val !== model_a || B_val !== model_b) begin failures++; $display("FAIL b2b_ab got=%h/%h exp=%h/%h", A_val, B_val, model_a, model_b); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++)
            run_frame("random", 7'($urandom), 7'($urandom), $urandom_range(3) == 0, $urandom_range(3) != 0, -1, 0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_parity_error();
        test_valid_frame();
        test_frame_error();
        test_false_start();
        test_reset_mid_frame();
        test_glitch();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
